// File: rtl/aes_csr_pkg.sv
// Shared register map, field positions and address decode for the AES CSR responder.
package aes_csr_pkg;

  localparam logic [31:0] KEY_OFFSET    = 32'h00;
  localparam logic [31:0] IV_OFFSET     = 32'h20;
  localparam logic [31:0] DIN_OFFSET    = 32'h30;
  localparam logic [31:0] DOUT_OFFSET   = 32'h40;
  localparam logic [31:0] CTRL_OFFSET   = 32'h50;
  localparam logic [31:0] TRIG_OFFSET   = 32'h54;
  localparam logic [31:0] STATUS_OFFSET = 32'h58;

  localparam int unsigned CTRL_MODE_BIT         = 0;
  localparam int unsigned CTRL_KEY_LEN_LSB      = 1;
  localparam int unsigned TRIG_START_BIT        = 0;
  localparam int unsigned TRIG_CLR_DOUT_BIT     = 1;
  localparam int unsigned STATUS_IDLE_BIT       = 0;
  localparam int unsigned STATUS_IN_READY_BIT   = 1;
  localparam int unsigned STATUS_OUT_VALID_BIT  = 2;

  typedef enum logic [1:0] {
    KeyLen128  = 2'd0,
    KeyLen192  = 2'd1,
    KeyLen256  = 2'd2,
    KeyLenRsvd = 2'd3
  } key_len_e;

  typedef enum logic [2:0] {
    RegKey, RegIv, RegDin, RegDout, RegCtrl, RegTrig, RegStatus, RegNone
  } reg_e;

  typedef struct packed {
    reg_e       kind;
    logic [2:0] word;
    logic       legal;
  } csr_dec_t;

  function automatic csr_dec_t aes_csr_decode(input logic [31:0] addr);
    csr_dec_t dec;
    dec.kind = RegNone;
    dec.word = {1'b0, addr[3:2]};
    if (addr[1:0] == 2'b00) begin
      if (addr < IV_OFFSET) begin
        dec.kind = RegKey;
        dec.word = addr[4:2];
      end else if (addr < DIN_OFFSET) begin
        dec.kind = RegIv;
      end else if (addr < DOUT_OFFSET) begin
        dec.kind = RegDin;
      end else if (addr < CTRL_OFFSET) begin
        dec.kind = RegDout;
      end else if (addr == CTRL_OFFSET) begin
        dec.kind = RegCtrl;
      end else if (addr == TRIG_OFFSET) begin
        dec.kind = RegTrig;
      end else if (addr == STATUS_OFFSET) begin
        dec.kind = RegStatus;
      end
    end
    dec.legal = (dec.kind != RegNone);
    return dec;
  endfunction

endpackage

// File: rtl/aes_csr_responder.sv
// CSR slave for one AES core: holds key/IV/data/control, issues start, captures result.
module aes_csr_responder
  import aes_csr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  acc_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  err,
  output logic [255:0]          key_o,
  output logic [127:0]          iv_o,
  output logic [127:0]          din_o,
  output logic                  mode_o,
  output logic [1:0]            key_len_o,
  output logic                  start_o,
  input  logic                  busy_i,
  input  logic                  done_i,
  input  logic [127:0]          dout_i
);

  logic [DATA_WIDTH-1:0] key_q  [8];
  logic [DATA_WIDTH-1:0] iv_q   [4];
  logic [DATA_WIDTH-1:0] din_q  [4];
  logic [DATA_WIDTH-1:0] dout_q [4];
  logic                  mode_q;
  key_len_e              key_len_q;
  logic [3:0]            din_mask_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  err_q;
  logic                  start_q;

  csr_dec_t              dec;
  logic                  in_ready;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_ok;
  logic                  start_ok;
  logic                  clr_dout;
  key_len_e              wr_key_len;

  assign dec        = aes_csr_decode(32'(addr));
  assign in_ready   = &din_mask_q;
  assign wr_key_len = key_len_e'(wdata[CTRL_KEY_LEN_LSB +: 2]);

  always_comb begin
    acc_err = 1'b0;
    rd_data = '0;
    if (acc_en) begin
      if (!dec.legal) begin
        acc_err = 1'b1;
      end else if (wr_en) begin
        case (dec.kind)
          RegKey, RegIv, RegDin: acc_err = busy_i;
          RegCtrl:               acc_err = busy_i || (wr_key_len == KeyLenRsvd);
          RegTrig:               acc_err = wdata[TRIG_START_BIT] && (busy_i || !in_ready);
          default:               acc_err = 1'b1; // DOUT and STATUS are read-only
        endcase
      end else begin
        // Write-only registers read back as zero without error.
        case (dec.kind)
          RegIv:   rd_data = iv_q[dec.word[1:0]];
          RegDout: rd_data = dout_q[dec.word[1:0]];
          RegCtrl: begin
            rd_data[CTRL_MODE_BIT]         = mode_q;
            rd_data[CTRL_KEY_LEN_LSB +: 2] = key_len_q;
          end
          RegStatus: begin
            rd_data[STATUS_IDLE_BIT]      = !busy_i;
            rd_data[STATUS_IN_READY_BIT]  = in_ready;
            rd_data[STATUS_OUT_VALID_BIT] = out_valid_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_ok    = acc_en && wr_en && !acc_err;
  assign start_ok = wr_ok && (dec.kind == RegTrig) && wdata[TRIG_START_BIT];
  assign clr_dout = (wr_ok && (dec.kind == RegTrig) && wdata[TRIG_CLR_DOUT_BIT]) ||
                    (acc_en && !wr_en && (dec.kind == RegDout) && (dec.word[1:0] == 2'd3));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) key_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        iv_q[i]   <= '0;
        din_q[i]  <= '0;
        dout_q[i] <= '0;
      end
      mode_q      <= 1'b0;
      key_len_q   <= KeyLen128;
      din_mask_q  <= '0;
      out_valid_q <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      rvalid_q <= acc_en && !wr_en;
      rdata_q  <= rd_data;
      err_q    <= acc_err;
      start_q  <= start_ok;

      if (wr_ok) begin
        case (dec.kind)
          RegKey: key_q[dec.word]      <= wdata;
          RegIv:  iv_q[dec.word[1:0]]  <= wdata;
          RegDin: din_q[dec.word[1:0]] <= wdata;
          RegCtrl: begin
            mode_q    <= wdata[CTRL_MODE_BIT];
            key_len_q <= wr_key_len;
          end
          default: ;
        endcase
      end

      if (start_ok) begin
        din_mask_q <= '0;
      end else if (wr_ok && (dec.kind == RegDin)) begin
        din_mask_q[dec.word[1:0]] <= 1'b1;
      end

      // A completion in the same cycle as a clear leaves the new result valid.
      if (done_i) begin
        out_valid_q <= 1'b1;
        for (int i = 0; i < 4; i++) dout_q[i] <= dout_i[32*i +: 32];
      end else if (clr_dout) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign start_o   = start_q;
  assign mode_o    = mode_q;
  assign key_len_o = key_len_q;
  assign key_o     = {key_q[7], key_q[6], key_q[5], key_q[4],
                      key_q[3], key_q[2], key_q[1], key_q[0]};
  assign iv_o      = {iv_q[3], iv_q[2], iv_q[1], iv_q[0]};
  assign din_o     = {din_q[3], din_q[2], din_q[1], din_q[0]};

endmodule

// File: tb/tb_aes_csr_responder.sv
// Directed bench for aes_csr_responder with hand-computed expectations.
module tb_aes_csr_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         acc_en = 1'b0;
  logic         wr_en = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         rvalid;
  logic         err;
  logic [255:0] key_o;
  logic [127:0] iv_o;
  logic [127:0] din_o;
  logic         mode_o;
  logic [1:0]   key_len_o;
  logic         start_o;
  logic         busy = 1'b0;
  logic         done = 1'b0;
  logic [127:0] dout = '0;

  int unsigned  n_total = 0;
  int unsigned  n_pass = 0;

  logic [31:0]  got_rdata;
  logic         got_rvalid;
  logic         got_err;
  logic         got_start;
  logic         watch_rvalid = 1'b0;
  logic         saw_rvalid = 1'b0;

  aes_csr_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .acc_en    (acc_en),
    .wr_en     (wr_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .err       (err),
    .key_o     (key_o),
    .iv_o      (iv_o),
    .din_o     (din_o),
    .mode_o    (mode_o),
    .key_len_o (key_len_o),
    .start_o   (start_o),
    .busy_i    (busy),
    .done_i    (done),
    .dout_i    (dout)
  );

  always #5 clk = ~clk;

  always @(rvalid) if (rvalid && watch_rvalid) saw_rvalid = 1'b1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one access for a cycle; capture the registered response half a cycle later.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    acc_en = 1'b1;
    wr_en  = w;
    addr   = a;
    wdata  = d;
    @(negedge clk);
    acc_en = 1'b0;
    wr_en  = 1'b0;
    got_rdata  = rdata;
    got_rvalid = rvalid;
    got_err    = err;
    got_start  = start_o;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    access(1'b0, a, 32'h0);
    chk({tag, "_rvalid"}, 256'(got_rvalid), 256'(1'b1));
    chk(tag, 256'(got_rdata), 256'(exp));
  endtask

  task automatic pulse_done(input logic [127:0] v);
    @(negedge clk);
    done = 1'b1;
    dout = v;
    @(negedge clk);
    done = 1'b0;
  endtask

  logic [31:0] kw [8];
  logic [31:0] ivw [4];
  logic [31:0] dw [4];

  initial begin
    for (int i = 0; i < 8; i++) kw[i] = 32'hA0A0_0000 | 32'(i);
    for (int i = 0; i < 4; i++) begin
      ivw[i] = 32'h1111_0000 + 32'(i);
      dw[i]  = 32'h2222_0000 + 32'(i);
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 256'(rvalid), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_start", 256'(start_o), 256'(0));
    chk("rst_key", key_o, 256'(0));
    chk("rst_keylen", 256'(key_len_o), 256'(0));
    rst = 1'b0;

    rd_chk("status_idle", 32'h58, 32'h1);
    chk("status_idle_err", 256'(got_err), 256'(0));

    // Load key/IV/data/control
    for (int i = 0; i < 8; i++) access(1'b1, 32'(4 * i), kw[i]);
    for (int i = 0; i < 4; i++) access(1'b1, 32'h20 + 32'(4 * i), ivw[i]);
    for (int i = 0; i < 4; i++) access(1'b1, 32'h30 + 32'(4 * i), dw[i]);
    access(1'b1, 32'h50, 32'h4);
    chk("ctrl_wr_err", 256'(got_err), 256'(0));
    rd_chk("status_ready", 32'h58, 32'h3);
    chk("key_o", key_o, {kw[7], kw[6], kw[5], kw[4], kw[3], kw[2], kw[1], kw[0]});
    chk("iv_o", 256'(iv_o), 256'({ivw[3], ivw[2], ivw[1], ivw[0]}));
    chk("din_o", 256'(din_o), 256'({dw[3], dw[2], dw[1], dw[0]}));
    chk("key_len_o", 256'(key_len_o), 256'(2));
    chk("mode_o", 256'(mode_o), 256'(0));
    rd_chk("ctrl_rd", 32'h50, 32'h4);
    rd_chk("key0_rd_zero", 32'h00, 32'h0);
    chk("key0_rd_noerr", 256'(got_err), 256'(0));
    rd_chk("iv2_rd", 32'h28, ivw[2]);

    // Start
    access(1'b1, 32'h54, 32'h1);
    chk("start_pulse", 256'(got_start), 256'(1));
    chk("start_noerr", 256'(got_err), 256'(0));
    @(negedge clk);
    chk("start_one_cycle", 256'(start_o), 256'(0));
    rd_chk("status_mask_clr", 32'h58, 32'h1);

    // Busy
    busy = 1'b1;
    access(1'b1, 32'h20, 32'hDEAD);
    chk("iv_busy_err", 256'(got_err), 256'(1));
    rd_chk("iv0_kept", 32'h20, ivw[0]);
    chk("iv0_rd_noerr", 256'(got_err), 256'(0));
    rd_chk("status_busy", 32'h58, 32'h0);
    access(1'b1, 32'h54, 32'h1);
    chk("trig_busy_err", 256'(got_err), 256'(1));
    chk("trig_busy_nostart", 256'(got_start), 256'(0));
    busy = 1'b0;

    // Result capture
    pulse_done(128'h01234567_89ABCDEF_FEDCBA98_76543210);
    rd_chk("status_outv", 32'h58, 32'h5);
    rd_chk("dout0", 32'h40, 32'h76543210);
    rd_chk("dout1", 32'h44, 32'hFEDCBA98);
    rd_chk("dout2", 32'h48, 32'h89ABCDEF);
    rd_chk("dout3", 32'h4C, 32'h01234567);
    rd_chk("status_outv_clr", 32'h58, 32'h1);

    pulse_done(128'h11223344_55667788_99AABBCC_DDEEFF00);
    @(negedge clk);
    acc_en = 1'b1;
    wr_en  = 1'b0;
    addr   = 32'h4C;
    done   = 1'b1;
    dout   = 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0;
    @(negedge clk);
    acc_en = 1'b0;
    done   = 1'b0;
    chk("dout3_race_rd", 256'(rdata), 256'(32'h11223344));
    rd_chk("status_set_wins", 32'h58, 32'h5);
    rd_chk("dout0_new", 32'h40, 32'h9ABCDEF0);
    access(1'b1, 32'h54, 32'h2);
    chk("clr_noerr", 256'(got_err), 256'(0));
    rd_chk("status_clr_dout", 32'h58, 32'h1);

    // Errors
    access(1'b0, 32'h5C, 32'h0);
    chk("unmapped_err", 256'(got_err), 256'(1));
    chk("unmapped_rvalid", 256'(got_rvalid), 256'(1));
    chk("unmapped_rdata", 256'(got_rdata), 256'(0));
    access(1'b1, 32'h22, 32'h1234);
    chk("misalign_err", 256'(got_err), 256'(1));
    rd_chk("iv0_after_misalign", 32'h20, ivw[0]);
    access(1'b1, 32'h50, 32'h6);
    chk("ctrl_rsvd_err", 256'(got_err), 256'(1));
    rd_chk("ctrl_unchanged", 32'h50, 32'h4);
    access(1'b1, 32'h40, 32'h5555);
    chk("dout_ro_err", 256'(got_err), 256'(1));
    for (int i = 0; i < 3; i++) access(1'b1, 32'h30 + 32'(4 * i), 32'h3333_0000);
    access(1'b1, 32'h54, 32'h1);
    chk("trig_not_ready_err", 256'(got_err), 256'(1));
    chk("trig_not_ready_nostart", 256'(got_start), 256'(0));

    // Reset during a read
    @(negedge clk);
    acc_en = 1'b1;
    wr_en  = 1'b0;
    addr   = 32'h20;
    watch_rvalid = 1'b1;
    #4 rst = 1'b1;
    @(negedge clk);
    acc_en = 1'b0;
    @(negedge clk);
    watch_rvalid = 1'b0;
    chk("rst_no_rvalid", 256'(saw_rvalid), 256'(0));
    chk("rst_rdata", 256'(rdata), 256'(0));
    chk("rst_key_clr", key_o, 256'(0));
    chk("rst_iv_clr", 256'(iv_o), 256'(0));
    chk("rst_din_clr", 256'(din_o), 256'(0));
    chk("rst_keylen_clr", 256'(key_len_o), 256'(0));
    chk("rst_err_clr", 256'(err), 256'(0));
    rst = 1'b0;
    rd_chk("status_after_rst", 32'h58, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
